// File: rtl/thermo_pkg.sv
// Shared thermostat-loop definitions: mode encoding, temperature width and a
// saturating clamp used by the plant and its sensor-noise path.
package thermo_pkg;

  localparam int TEMP_W = 5;
  localparam logic [TEMP_W-1:0] TEMP_MAX = 5'd31;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_COOL = 2'b01,
    MODE_HEAT = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  // Wide enough that rate additions and subtractions never overflow before clamping.
  typedef logic signed [TEMP_W+2:0] temp_wide_t;

  function automatic logic [TEMP_W-1:0] clamp_temp(input temp_wide_t v);
    if (v[TEMP_W+2]) begin
      return '0;
    end else if (v > temp_wide_t'(TEMP_MAX)) begin
      return TEMP_MAX;
    end else begin
      return v[TEMP_W-1:0];
    end
  endfunction

endpackage

// File: rtl/room_temp_model_if.sv
// Thermostat <-> room plant bus: mode/load commands in, temperature and flags out.
interface room_temp_model_if;
  import thermo_pkg::*;

  logic [1:0]        mode;
  logic              load;
  logic [TEMP_W-1:0] load_temp;
  logic [TEMP_W-1:0] temp;
  logic              temp_valid;
  logic              sat_hi;
  logic              sat_lo;

  modport master (
    output mode, load, load_temp,
    input  temp, temp_valid, sat_hi, sat_lo
  );

  modport slave (
    input  mode, load, load_temp,
    output temp, temp_valid, sat_hi, sat_lo
  );
endinterface

// File: rtl/thermo_noise_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5) supplying sensor-noise select bits.
module thermo_noise_lfsr (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  output logic [1:0] noise
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign noise = lfsr_q[1:0];

endmodule

// File: rtl/room_temp_model.sv
// Thermal plant for the thermostat loop: heats, cools or drifts to ambient once per
// STEP_CYCLES clocks. Optional sensor noise on the reported value: SENSOR_NOISE_EN.
module room_temp_model
  import thermo_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned HEAT_RATE   = 2,
  parameter int unsigned COOL_RATE   = 2,
  parameter int unsigned DRIFT_RATE  = 1,
  parameter int unsigned AMBIENT     = 16,
  parameter int unsigned RESET_TEMP  = 16
) (
  input logic               clk,
  input logic               rst,
  room_temp_model_if.slave  bus
);

  localparam int                CNT_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STEP_CYCLES - 1);
  localparam logic [TEMP_W-1:0] RESET_VAL = TEMP_W'(RESET_TEMP);
  localparam temp_wide_t        AMB_W     = temp_wide_t'(AMBIENT);
  localparam temp_wide_t        HEAT_W    = temp_wide_t'(HEAT_RATE);
  localparam temp_wide_t        COOL_W    = temp_wide_t'(COOL_RATE);
  localparam temp_wide_t        DRIFT_W   = temp_wide_t'(DRIFT_RATE);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TEMP_W-1:0] true_temp_q, true_temp_d;
  logic              valid_q, valid_d;
  logic              sat_hi_q, sat_hi_d;
  logic              sat_lo_q, sat_lo_d;
  logic              tick;
  mode_e             mode_s;
  temp_wide_t        t_w, gap, step_w;

  assign tick   = (cnt_q == CNT_LAST);
  assign mode_s = mode_e'(bus.mode);
  assign t_w    = temp_wide_t'({1'b0, true_temp_q});
  assign gap    = AMB_W - t_w;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    step_w = '0;
    case (mode_s)
      MODE_HEAT: step_w = HEAT_W;
      MODE_COOL: step_w = -COOL_W;
      default: begin
        if (gap > DRIFT_W) begin
          step_w = DRIFT_W;
        end else if (gap < -DRIFT_W) begin
          step_w = -DRIFT_W;
        end else begin
          step_w = gap;
        end
      end
    endcase
  end

  // load wins over a coincident tick and restarts the step period.
  always_comb begin
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    true_temp_d = true_temp_q;
    valid_d     = 1'b0;
    if (bus.load) begin
      cnt_d       = '0;
      true_temp_d = bus.load_temp;
      valid_d     = 1'b1;
    end else if (tick) begin
      true_temp_d = clamp_temp(t_w + step_w);
      valid_d     = 1'b1;
    end
    sat_hi_d = (true_temp_d == TEMP_MAX);
    sat_lo_d = (true_temp_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      true_temp_q <= RESET_VAL;
      valid_q     <= 1'b0;
      sat_hi_q    <= (RESET_VAL == TEMP_MAX);
      sat_lo_q    <= (RESET_VAL == '0);
    end else begin
      cnt_q       <= cnt_d;
      true_temp_q <= true_temp_d;
      valid_q     <= valid_d;
      sat_hi_q    <= sat_hi_d;
      sat_lo_q    <= sat_lo_d;
    end
  end

  assign bus.temp_valid = valid_q;
  assign bus.sat_hi     = sat_hi_q;
  assign bus.sat_lo     = sat_lo_q;

`ifdef SENSOR_NOISE_EN
  logic [1:0]        noise_bits;
  logic [TEMP_W-1:0] temp_q, temp_d;
  temp_wide_t        noise_w;

  thermo_noise_lfsr u_noise (
    .clk   (clk),
    .rst   (rst),
    .adv   (tick),
    .noise (noise_bits)
  );

  // Noise only perturbs the reported value; the plant state stays clean.
  always_comb begin
    case (noise_bits)
      2'b01:   noise_w = 8'sd1;
      2'b10:   noise_w = -8'sd1;
      default: noise_w = '0;
    endcase
    temp_d = temp_q;
    if (bus.load || tick) begin
      temp_d = clamp_temp(temp_wide_t'({1'b0, true_temp_d}) + noise_w);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      temp_q <= RESET_VAL;
    end else begin
      temp_q <= temp_d;
    end
  end

  assign bus.temp = temp_q;
`else
  assign bus.temp = true_temp_q;
`endif

endmodule
